fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the hazard unit's consumers.
- Owns the fetch PC and the instruction-memory request/ready handshake, and produces the IF/ID pipeline register.
- Consumes the hazard unit's 5-bit stall/flush vectors (bit 4 = IF, bit 3 = ID) and the redirect target computed in ID.
- Tolerates multi-cycle instruction memory, discards wrong-path responses, and buffers a fetched word across stalls.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, encoding written into IF/ID for a bubble

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  5  hazard-unit stall vector; bit4 stall IF, bit3 stall ID
flush  in  5  hazard-unit flush vector; bit4 flush IF (redirect)
id_target  in  32  redirect PC from ID (branch/j/jal/jr/jalr); bits[1:0] ignored, treated as 00
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address; stable while imem_req high and not yet accepted
imem_ready  in  1  response valid; transfer completes on imem_req && imem_ready
imem_rdata  in  32  instruction word, valid with imem_ready
if_id_inst  out  32  IF/ID instruction
if_id_pc_plus4  out  32  IF/ID fetch address + 4
if_id_valid  out  1  IF/ID holds a real instruction
if_pc  out  32  current fetch address register (debug)

Behaviour:
- Reset (async, reset_n=0): state IDLE; imem_req=0; imem_addr=if_pc=RESET_PC; if_id_inst=NOP_INST; if_id_pc_plus4=0; if_id_valid=0; hold buffer empty; pending target=0.
- Reset mid-transaction abandons any outstanding request; instruction memory shares reset_n.
- redirect = flush[4] && !stall[3]. Redirect is suppressed while ID is stalled, because the ID decision is not final.
- IF/ID update priority:
  1) stall[3]: hold.
  2) redirect: bubble (NOP_INST, valid=0, pc_plus4 unchanged).
  3) New word delivered this cycle: load inst, fa+4, valid=1.
  4) Otherwise: bubble.
- FSM states (fa = fetch address register = imem_addr = if_pc):
  - IDLE: imem_req=0 for one cycle after reset release -> REQ.
  - REQ: imem_req=1.
    - ready && redirect: discard word; fa<=id_target; stay REQ.
    - ready && stall[4]: word -> hold buffer; fa<=fa+4; -> HOLD.
    - ready, no stall: word delivered to IF/ID; fa<=fa+4; stay REQ.
    - !ready && redirect: pending<=id_target; -> DROP.
    - !ready, no redirect: stay REQ, fa unchanged.
  - DROP: imem_req=1, addr = old fa, stable until accepted.
    - Redirect in DROP overwrites pending; latest wins.
    - On ready: discard word; fa<=pending; -> REQ.
  - HOLD: imem_req=0.
    - redirect: discard buffer; fa<=id_target; -> REQ.
    - !stall[4]: buffer delivered to IF/ID with pc_plus4 = buffered address+4; -> REQ.
    - Else stay.
- Latency: zero-wait memory gives one instruction per cycle; word accepted in cycle N appears on IF/ID after edge N.
- fa+4 wraps modulo 2^32.
- stall and flush bits other than [4:3] are ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN, when defined:
  - Adds outputs perf_fetch_cnt[31:0] (IF/ID loads with valid=1) and perf_bubble_cnt[31:0] (IF/ID bubble writes).
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: ports and logic are absent, with no change to other behaviour.

Test Plan:
- Reset release, imem_ready tied 1, rdata=addr -> IDLE one cycle, then addr 0x00400000,04,08; IF/ID valid each cycle with pc_plus4 = addr+4.
- ready=0 for 3 cycles at 0x00400008 -> addr held stable, IF/ID bubbles (valid=0, inst=0) for 3 cycles, then word loaded.
- Redirect (flush=5'b10000, id_target=0x00400100) while request pending -> DROP; old response discarded; next request at 0x00400100; IF/ID never shows old word.
- stall=5'b11000 two cycles with ready=1 -> one word buffered, IF/ID held, imem_req=0 in HOLD; on release buffered word loaded, then fetch continues at +4.
- flush=5'b10000 with stall=5'b11000 simultaneously -> no redirect, IF/ID held; redirect takes effect the cycle stall drops.
- reset_n pulsed low mid-DROP -> all outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, the instruction-memory request handshake and the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds IF/ID load and bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  stall,
  input  logic [4:0]  flush,
  input  logic [31:0] id_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] if_pc,
  output logic [1:0]  fsm_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  // Handshake: a transfer completes on a cycle with imem_req && imem_ready;
  // imem_addr is held stable while imem_req is high and not yet accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fa, fa_nxt;
  logic [31:0] pending, pending_nxt;
  logic [31:0] hold_inst, hold_inst_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic        redirect;
  logic        deliver;
  logic [31:0] dlv_inst, dlv_pc4;
  logic [31:0] target_al;
  logic        unused_bits;

  // An ID decision is not final while ID itself is stalled.
  assign redirect    = flush[4] && !stall[3];
  assign target_al   = {id_target[31:2], 2'b00};
  assign unused_bits = ^{stall[2:0], flush[3:0], id_target[1:0]};

  assign imem_addr = fa;
  assign if_pc     = fa;
  assign fsm_state = state;

  always_comb begin
    state_nxt     = state;
    fa_nxt        = fa;
    pending_nxt   = pending;
    hold_inst_nxt = hold_inst;
    hold_pc_nxt   = hold_pc;
    imem_req      = 1'b0;
    deliver       = 1'b0;
    dlv_inst      = imem_rdata;
    dlv_pc4       = fa + 32'd4;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect) begin
            fa_nxt = target_al;
          end else if (stall[4]) begin
            hold_inst_nxt = imem_rdata;
            hold_pc_nxt   = fa;
            fa_nxt        = fa + 32'd4;
            state_nxt     = HOLD;
          end else begin
            deliver = 1'b1;
            fa_nxt  = fa + 32'd4;
          end
        end else if (redirect) begin
          pending_nxt = target_al;
          state_nxt   = DROP;
        end
      end
      DROP: begin
        // The old address stays on the bus until memory accepts it; the word is wrong-path.
        imem_req = 1'b1;
        if (redirect) pending_nxt = target_al;
        if (imem_ready) begin
          fa_nxt    = redirect ? target_al : pending;
          state_nxt = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          fa_nxt    = target_al;
          state_nxt = REQ;
        end else if (!stall[4]) begin
          deliver   = 1'b1;
          dlv_inst  = hold_inst;
          dlv_pc4   = hold_pc + 32'd4;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fa        <= RESET_PC;
      pending   <= 32'd0;
      hold_inst <= NOP_INST;
      hold_pc   <= 32'd0;
    end else begin
      state     <= state_nxt;
      fa        <= fa_nxt;
      pending   <= pending_nxt;
      hold_inst <= hold_inst_nxt;
      hold_pc   <= hold_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_inst     <= NOP_INST;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (!stall[3]) begin
      if (deliver && !redirect) begin
        if_id_inst     <= dlv_inst;
        if_id_pc_plus4 <= dlv_pc4;
        if_id_valid    <= 1'b1;
      end else begin
        if_id_inst  <= NOP_INST;
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else if (!stall[3]) begin
      if (deliver && !redirect) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      else perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
